// File: rtl/subleq_mem_arbiter.sv
// Two-master arbiter in front of the single-ported SUBLEQ word memory.
// Port 0 is the controller/datapath master, port 1 the loader/debug master.
// Both masters and the memory slave use a 4-phase req/ack handshake.
//
// Ports:
//   clk, areset             clock, synchronous active-high reset
//   req0/we0/addr0/wdata0   port 0 request bundle, ack0 returned to it
//   req1/we1/addr1/wdata1   port 1 request bundle, ack1 returned to it
//   lock1                   port 1 keeps the bus across back-to-back transfers
//   rdata                   memory read data broadcast to both masters
//   mem_req/we/addr/wdata   request bundle towards the memory slave
//   mem_ack, mem_rdata      memory slave response
//   grant, busy             one-hot current owner, and grant != 0
module subleq_mem_arbiter #(
   parameter int unsigned WORD_BITS      = 16,
   parameter bit          FIXED_PRIORITY = 1'b0
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 req0,
   input  logic                 we0,
   input  logic [WORD_BITS-1:0] addr0,
   input  logic [WORD_BITS-1:0] wdata0,
   output logic                 ack0,
   input  logic                 req1,
   input  logic                 we1,
   input  logic [WORD_BITS-1:0] addr1,
   input  logic [WORD_BITS-1:0] wdata1,
   input  logic                 lock1,
   output logic                 ack1,
   output logic [WORD_BITS-1:0] rdata,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [WORD_BITS-1:0] mem_addr,
   output logic [WORD_BITS-1:0] mem_wdata,
   input  logic                 mem_ack,
   input  logic [WORD_BITS-1:0] mem_rdata,
   output logic [1:0]           grant,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_ACKED   = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;
   logic   last_q,  last_d;
   logic   req_own;
   logic   winner;

   // Request of whichever port currently owns the bus.
   assign req_own = owner_q ? req1 : req0;

   // Tie-break: fixed priority favours port 0, round-robin favours the port
   // that did not complete the previous transaction.
   always_comb begin
      if (req0 && req1) begin
         winner = FIXED_PRIORITY ? 1'b0 : ~last_q;
      end else begin
         winner = req1;
      end
   end

   // State, owner and last-served registers.
   always_ff @(posedge clk) begin
      if (areset) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic and bus mux.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      grant     = 2'b00;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      ack0      = 1'b0;
      ack1      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               owner_d = winner;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // A locked port 1 may sit here between transfers with req1 low;
            // anyone else dropping req before ack abandons the grant.
            if (mem_ack) begin
               state_d = ST_ACKED;
            end else if (!req_own && !(owner_q && lock1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_ACKED: begin
            if (!req_own && !mem_ack) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            last_d  = owner_q;
            state_d = (owner_q && lock1) ? ST_GRANT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_q != ST_IDLE) begin
         grant     = owner_q ? 2'b10 : 2'b01;
         mem_req   = req_own && ((state_q == ST_GRANT) || (state_q == ST_ACKED));
         mem_we    = owner_q ? we1 : we0;
         mem_addr  = owner_q ? addr1 : addr0;
         mem_wdata = owner_q ? wdata1 : wdata0;
         ack0      = ~owner_q & mem_ack;
         ack1      = owner_q & mem_ack;
      end
   end

   assign busy  = |grant;
   assign rdata = mem_rdata;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Scoreboard bench: instance 0 is round-robin, instance 1 fixed priority,
// each behind its own 2-cycle-latency memory slave model.
`timescale 1ns/1ps
module tb_subleq_mem_arbiter;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } exp_t;

   localparam int BUDGET = 100;

   logic        clk;
   logic        areset;
   logic        req0_s [2];
   logic        we0_s [2];
   logic [15:0] addr0_s [2];
   logic [15:0] wdata0_s [2];
   logic        ack0_s [2];
   logic        req1_s [2];
   logic        we1_s [2];
   logic [15:0] addr1_s [2];
   logic [15:0] wdata1_s [2];
   logic        lock1_s [2];
   logic        ack1_s [2];
   logic [15:0] rdata_s [2];
   logic        mem_req_s [2];
   logic        mem_we_s [2];
   logic [15:0] mem_addr_s [2];
   logic [15:0] mem_wdata_s [2];
   logic        mem_ack_s [2];
   logic [15:0] mem_rdata_s [2];
   logic [1:0]  grant_s [2];
   logic        busy_s [2];

   logic [15:0] mem_m [2][256];
   int          dly_cnt [2];
   exp_t        sb_q [4][$];
   logic        ack_prev [2][2];

   int n_vec = 0;
   int n_err = 0;
   int p0_cnt;
   int glitch;
   bit p1_done;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      subleq_mem_arbiter #(.WORD_BITS(16), .FIXED_PRIORITY(g == 1)) u_dut (
         .clk(clk), .areset(areset),
         .req0(req0_s[g]), .we0(we0_s[g]), .addr0(addr0_s[g]), .wdata0(wdata0_s[g]), .ack0(ack0_s[g]),
         .req1(req1_s[g]), .we1(we1_s[g]), .addr1(addr1_s[g]), .wdata1(wdata1_s[g]),
         .lock1(lock1_s[g]), .ack1(ack1_s[g]), .rdata(rdata_s[g]),
         .mem_req(mem_req_s[g]), .mem_we(mem_we_s[g]), .mem_addr(mem_addr_s[g]),
         .mem_wdata(mem_wdata_s[g]), .mem_ack(mem_ack_s[g]), .mem_rdata(mem_rdata_s[g]),
         .grant(grant_s[g]), .busy(busy_s[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ack_of(input int d, input int p);
      return (p == 0) ? ack0_s[d] : ack1_s[d];
   endfunction

   // Memory slave: ack two cycles after mem_req, hold until mem_req drops.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (areset) begin
            mem_ack_s[d]   <= 1'b0;
            mem_rdata_s[d] <= 16'h0;
            dly_cnt[d]     <= 0;
            for (int i = 0; i < 256; i++) begin
               mem_m[d][i] <= (i == 16) ? 16'h1234 : 16'(32'h1000 + i);
            end
         end else if (mem_req_s[d] && !mem_ack_s[d]) begin
            if (dly_cnt[d] == 1) begin
               mem_ack_s[d] <= 1'b1;
               dly_cnt[d]   <= 0;
               if (mem_we_s[d]) mem_m[d][mem_addr_s[d][7:0]] <= mem_wdata_s[d];
               else             mem_rdata_s[d] <= mem_m[d][mem_addr_s[d][7:0]];
            end else begin
               dly_cnt[d] <= dly_cnt[d] + 1;
            end
         end else if (!mem_req_s[d]) begin
            mem_ack_s[d] <= 1'b0;
            dly_cnt[d]   <= 0;
         end
      end
   end

   // Scoreboard: on each rising ack pop the expected transfer for that port.
   always @(negedge clk) begin
      logic a;
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            a = ack_of(d, p);
            if (a && !ack_prev[d][p]) begin
               if (sb_q[d*2+p].size() == 0) begin
                  check_eq("unexpected_ack", 16'(sb_q[d*2+p].size()), 16'h1);
               end else begin
                  e = sb_q[d*2+p].pop_front();
                  check_eq("ack_grant", 16'(grant_s[d]), (p == 0) ? 16'h1 : 16'h2);
                  check_eq("ack_addr", mem_addr_s[d], e.addr);
                  check_eq("ack_we", 16'(mem_we_s[d]), 16'(e.we));
                  if (e.we) check_eq("ack_wdata", mem_wdata_s[d], e.data);
                  else      check_eq("ack_rdata", rdata_s[d], e.data);
               end
            end
            ack_prev[d][p] <= a;
         end
      end
   end

   task automatic set_req(input int d, input int p, input logic r);
      if (p == 0) req0_s[d] = r;
      else        req1_s[d] = r;
   endtask

   task automatic start_req(input int d, input int p, input logic w,
                            input logic [15:0] a, input logic [15:0] wd);
      exp_t e;
      e.we   = w;
      e.addr = a;
      e.data = w ? wd : mem_m[d][a[7:0]];
      sb_q[d*2+p].push_back(e);
      if (p == 0) begin we0_s[d] = w; addr0_s[d] = a; wdata0_s[d] = wd; end
      else        begin we1_s[d] = w; addr1_s[d] = a; wdata1_s[d] = wd; end
      set_req(d, p, 1'b1);
   endtask

   task automatic finish_req(input int d, input int p);
      int n;
      n = 0;
      while (!ack_of(d, p) && n < BUDGET) begin @(negedge clk); n++; end
      if (n >= BUDGET) check_eq("ack_timeout", 16'(ack_of(d, p)), 16'h1);
      @(posedge clk); #1;
      set_req(d, p, 1'b0);
      n = 0;
      while (ack_of(d, p) && n < BUDGET) begin @(negedge clk); n++; end
      if (n >= BUDGET) check_eq("ack_stuck", 16'(ack_of(d, p)), 16'h0);
   endtask

   task automatic xfer(input int d, input int p, input logic w,
                       input logic [15:0] a, input logic [15:0] wd);
      start_req(d, p, w, a, wd);
      finish_req(d, p);
   endtask

   task automatic wait_grant(input int d, input logic [1:0] exp, input int budget, input string tag);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (grant_s[d] == 2'b00 && n < budget);
      check_eq(tag, 16'(grant_s[d]), 16'(exp));
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (grant_s[d] != 2'b00 && n < 20) begin @(negedge clk); n++; end
      check_eq("idle", 16'(grant_s[d]), 16'h0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1 areset = 1'b1;
      @(posedge clk); #1 areset = 1'b0;
   endtask

   initial begin
      areset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req0_s[d] = 0; we0_s[d] = 0; addr0_s[d] = 0; wdata0_s[d] = 0;
         req1_s[d] = 0; we1_s[d] = 0; addr1_s[d] = 0; wdata1_s[d] = 0;
         lock1_s[d] = 0;
      end
      // Port 0 active during reset must not reach the memory bus.
      req0_s[0] = 1; we0_s[0] = 1; addr0_s[0] = 16'h0055; wdata0_s[0] = 16'h0077;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_grant", 16'(grant_s[0]), 16'h0);
      check_eq("rst_busy", 16'(busy_s[0]), 16'h0);
      check_eq("rst_mem_req", 16'(mem_req_s[0]), 16'h0);
      check_eq("rst_mem_we", 16'(mem_we_s[0]), 16'h0);
      check_eq("rst_mem_addr", mem_addr_s[0], 16'h0);
      check_eq("rst_mem_wdata", mem_wdata_s[0], 16'h0);
      check_eq("rst_ack0", 16'(ack0_s[0]), 16'h0);
      check_eq("rst_ack1", 16'(ack1_s[0]), 16'h0);
      @(posedge clk); #1;
      areset = 0; req0_s[0] = 0; we0_s[0] = 0;

      // Single read from port 0.
      @(posedge clk); #1;
      start_req(0, 0, 1'b0, 16'h0010, 16'h0);
      @(negedge clk);
      check_eq("t1_grant_pre", 16'(grant_s[0]), 16'h0);
      @(negedge clk);
      check_eq("t1_grant", 16'(grant_s[0]), 16'h1);
      check_eq("t1_mem_req", 16'(mem_req_s[0]), 16'h1);
      check_eq("t1_mem_addr", mem_addr_s[0], 16'h0010);
      check_eq("t1_ack1", 16'(ack1_s[0]), 16'h0);
      finish_req(0, 0);
      @(negedge clk);
      check_eq("t1_release", 16'(grant_s[0]), 16'h1);
      @(negedge clk);
      check_eq("t1_idle", 16'(grant_s[0]), 16'h0);
      check_eq("t1_busy", 16'(busy_s[0]), 16'h0);

      // Round-robin ties.
      pulse_reset();
      fork
         xfer(0, 0, 1'b0, 16'h0011, 16'h0);
         xfer(0, 1, 1'b0, 16'h0012, 16'h0);
         wait_grant(0, 2'b01, 4, "t2_tie1");
      join
      wait_idle(0);
      @(posedge clk); #1;
      fork
         xfer(0, 0, 1'b0, 16'h0013, 16'h0);
         xfer(0, 1, 1'b0, 16'h0014, 16'h0);
         wait_grant(0, 2'b01, 4, "t2_tie2");
      join
      wait_idle(0);
      xfer(0, 0, 1'b0, 16'h0015, 16'h0);
      wait_idle(0);
      @(posedge clk); #1;
      fork
         xfer(0, 0, 1'b0, 16'h0016, 16'h0);
         xfer(0, 1, 1'b0, 16'h0017, 16'h0);
         wait_grant(0, 2'b10, 4, "t2_tie3");
      join
      wait_idle(0);

      // Fixed priority: port 0 keeps winning while both keep requesting.
      p0_cnt = 0;
      @(posedge clk); #1;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               xfer(1, 0, 1'b0, 16'(16'h0020 + k), 16'h0);
               p0_cnt++;
            end
         end
         begin
            xfer(1, 1, 1'b0, 16'h0028, 16'h0);
            check_eq("t3_fp_order", 16'(p0_cnt), 16'h3);
         end
      join
      wait_idle(1);

      // Locked port 1 burst of writes with port 0 waiting.
      wait_idle(0);
      p1_done = 0;
      glitch = 0;
      @(posedge clk); #1;
      lock1_s[0] = 1;
      fork
         begin
            for (int k = 0; k < 3; k++) xfer(0, 1, 1'b1, 16'(16'h0020 + k), 16'hAAAA);
            p1_done = 1;
            @(posedge clk); #1 lock1_s[0] = 0;
            @(negedge clk); check_eq("t4_release", 16'(grant_s[0]), 16'h2);
            @(negedge clk); check_eq("t4_gap", 16'(grant_s[0]), 16'h0);
            @(negedge clk); check_eq("t4_p0_grant", 16'(grant_s[0]), 16'h1);
         end
         begin
            wait_grant(0, 2'b10, 4, "t4_lock_grant");
            xfer(0, 0, 1'b0, 16'h0030, 16'h0);
         end
         begin
            repeat (2) @(negedge clk);
            while (!p1_done) begin
               if (grant_s[0] != 2'b10) glitch++;
               @(negedge clk);
            end
            check_eq("t4_lock_hold", 16'(glitch), 16'h0);
         end
      join
      for (int k = 0; k < 3; k++) check_eq("t4_mem_write", mem_m[0][8'h20 + k], 16'hAAAA);
      wait_idle(0);

      // Abandoned request leaves the round-robin pointer untouched.
      xfer(0, 1, 1'b0, 16'h0018, 16'h0);
      wait_idle(0);
      @(posedge clk); #1 addr0_s[0] = 16'h0050; we0_s[0] = 0; req0_s[0] = 1;
      @(posedge clk); #1 req0_s[0] = 0;
      @(negedge clk); check_eq("t5_ab_grant", 16'(grant_s[0]), 16'h1);
      @(negedge clk); check_eq("t5_ab_idle", 16'(grant_s[0]), 16'h0);
      @(posedge clk); #1;
      fork
         xfer(0, 0, 1'b0, 16'h0019, 16'h0);
         xfer(0, 1, 1'b0, 16'h001A, 16'h0);
         wait_grant(0, 2'b01, 4, "t5_last_kept");
      join
      wait_idle(0);
      // Abandon while port 1 is pending: port 1 follows two cycles later.
      @(posedge clk); #1 req0_s[0] = 1;
      @(posedge clk); #1 req0_s[0] = 0;
      fork
         xfer(0, 1, 1'b0, 16'h001B, 16'h0);
         begin
            @(negedge clk); check_eq("t5_ab2_grant", 16'(grant_s[0]), 16'h1);
            @(negedge clk); check_eq("t5_ab2_idle", 16'(grant_s[0]), 16'h0);
            @(negedge clk); check_eq("t5_p1_next", 16'(grant_s[0]), 16'h2);
         end
      join
      wait_idle(0);

      // Reset while a transfer sits in ACKED.
      @(posedge clk); #1;
      start_req(0, 0, 1'b0, 16'h001C, 16'h0);
      for (int n = 0; n < BUDGET && !ack0_s[0]; n++) @(negedge clk);
      check_eq("t6_ack_seen", 16'(ack0_s[0]), 16'h1);
      @(posedge clk); #1 areset = 1;
      @(posedge clk);
      @(negedge clk);
      check_eq("t6_grant", 16'(grant_s[0]), 16'h0);
      check_eq("t6_busy", 16'(busy_s[0]), 16'h0);
      check_eq("t6_mem_req", 16'(mem_req_s[0]), 16'h0);
      check_eq("t6_ack0", 16'(ack0_s[0]), 16'h0);
      check_eq("t6_ack1", 16'(ack1_s[0]), 16'h0);
      @(posedge clk); #1;
      areset = 0;
      req0_s[0] = 0;
      fork
         xfer(0, 1, 1'b0, 16'h001D, 16'h0);
         begin
            @(negedge clk); check_eq("t6_post_idle", 16'(grant_s[0]), 16'h0);
            @(negedge clk); check_eq("t6_p1_grant", 16'(grant_s[0]), 16'h2);
         end
      join
      wait_idle(0);

      for (int i = 0; i < 4; i++) check_eq("sb_drained", 16'(sb_q[i].size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
